// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings and the saturation limit of the BCD result.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_t;

  localparam int DEFAULT_DIGITS = 4;

  // Largest value representable with the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_val(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DEFAULT_DIGITS);

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional +3; the 4-bit result never needs a carry-out for valid digits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit is shifted per
// cycle, so a conversion takes BIN_W shift cycles plus one cycle to publish the
// result. Values above 10^DIGITS-1 saturate to all nines with ovf set.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask
);

  import bin_to_bcd_seq_pkg::*;

  localparam int                  CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0]         LIMIT     = max_val(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0]   MASK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(BIN_W - 1);

  bcd_state_t            state;
  logic [BIN_W-1:0]      shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [CNT_W-1:0]      step_cnt;
  logic                  ovf_pending;
  logic [4*DIGITS-1:0]   final_bcd;
  logic [DIGITS-1:0]     mask_next;

  // One add-3 corrector per decimal digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (adjusted[4*g +: 4])
    );
  end

  // Result to publish and its leading-zero mask; digit 0 is never blanked so zero shows as "0".
  always_comb begin
    logic zero_above;
    final_bcd  = ovf_pending ? ALL_NINES : scratch;
    mask_next  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above && (final_bcd[4*i +: 4] == 4'd0);
      mask_next[i] = zero_above;
    end
  end

  // Conversion FSM with registered outputs; starts are only accepted in IDLE.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= IDLE;
      shreg       <= '0;
      scratch     <= '0;
      step_cnt    <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_out     <= '0;
      ovf         <= 1'b0;
      blank_mask  <= MASK_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= bin_in;
            scratch     <= '0;
            step_cnt    <= '0;
            ovf_pending <= (64'(bin_in) > LIMIT);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch  <= {adjusted[4*DIGITS-2:0], shreg[BIN_W-1]};
          shreg    <= {shreg[BIN_W-2:0], 1'b0};
          step_cnt <= step_cnt + CNT_W'(1);
          if (step_cnt == LAST_STEP) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd_out    <= final_bcd;
          ovf        <= ovf_pending;
          blank_mask <= mask_next;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset_p;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;
  logic [3:0]  blank_mask;

  int checks;
  int errors;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .ovf        (ovf),
    .blank_mask (blank_mask)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference BCD via decimal arithmetic, independent of the shift-add-3 algorithm.
  function automatic logic [15:0] model_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] model_mask(input int v);
    if (v > 9999) return 4'b0000;
    return {(v < 1000), (v < 100), (v < 10), 1'b0};
  endfunction

  // Caller is at a negedge: pulse start for one cycle, wait for done, check latency and result.
  task automatic run_conv(input int value, input logic [15:0] exp_bcd, input logic exp_ovf,
                          input logic [3:0] exp_mask, input string tag);
    int cycles;
    bin_in = 14'(value);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, 64'(cycles), 64'd15);
    check({tag, " bcd"}, 64'(bcd_out), 64'(exp_bcd));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    check({tag, " mask"}, 64'(blank_mask), 64'(exp_mask));
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cycles;
    int done_seen;
    checks  = 0;
    errors  = 0;
    reset_p = 1'b1;
    start   = 1'b0;
    bin_in  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset bcd", 64'(bcd_out), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    check("reset mask", 64'(blank_mask), 64'b1110);

    // Start in the very first cycle after reset release.
    reset_p = 1'b0;
    run_conv(1234, 16'h1234, 1'b0, 4'b0000, "v1234");
    repeat (5) @(negedge clk);
    check("hold bcd", 64'(bcd_out), 64'h1234);
    check("hold mask", 64'(blank_mask), 64'b0000);

    run_conv(0,     16'h0000, 1'b0, 4'b1110, "v0");
    run_conv(7,     16'h0007, 1'b0, 4'b1110, "v7");
    run_conv(50,    16'h0050, 1'b0, 4'b1100, "v50");
    run_conv(9999,  16'h9999, 1'b0, 4'b0000, "v9999");
    run_conv(10000, 16'h9999, 1'b1, 4'b0000, "v10000");
    run_conv(16383, 16'h9999, 1'b1, 4'b0000, "v16383");
    run_conv(805,   16'h0805, 1'b0, 4'b1000, "v805");

    // Start held high: back-to-back conversions, one done every 16 cycles.
    bin_in = 14'd42;
    start  = 1'b1;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b first latency", 64'(cycles), 64'd16);
    check("b2b first bcd", 64'(bcd_out), 64'h0042);
    bin_in = 14'd43;
    @(negedge clk);
    cycles = 1;
    while (!done && cycles < 40) begin
      if (cycles == 3) bin_in = 14'd999;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("b2b period", 64'(cycles), 64'd16);
    check("b2b second bcd", 64'(bcd_out), 64'h0043);
    @(negedge clk);
    @(negedge clk);
    check("b2b no third", 64'(busy), 64'd0);

    // Reset in the middle of a conversion discards it.
    bin_in = 14'd8765;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid busy", 64'(busy), 64'd1);
    reset_p = 1'b1;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset bcd", 64'(bcd_out), 64'd0);
    check("mid reset ovf", 64'(ovf), 64'd0);
    check("mid reset mask", 64'(blank_mask), 64'b1110);
    repeat (2) @(negedge clk);
    reset_p   = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no done after reset", 64'(done_seen), 64'd0);
    run_conv(321, 16'h0321, 1'b0, 4'b1000, "v321");

    // Spread sweep against the decimal reference model.
    for (int v = 0; v < 16384; v += 257) begin
      run_conv(v, model_bcd(v), (v > 9999), model_mask(v), $sformatf("sweep %0d", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
